// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote bit sampling, glitch-filtered start,
// break detection and a small RX FIFO drained over valid/ready.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | line idle, waiting for a low sample on a baud tick
// S_START   | start bit; a majority-1 vote rejects it as a glitch
// S_DATA    | 5..8 data bits, LSB first
// S_PARITY  | parity bit (only when pen was set at frame start)
// S_STOP1   | first stop bit; the push happens here when stb=0
// S_STOP2   | second stop bit (stb=1)
// S_WAIT_HI | last stop sampled low, waiting for the line to go high
module uart_rx_fifo #(
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               sys_clk,
    input  logic                               reset,
    input  logic                               baud_tick,
    input  logic                               rxd_i,
    input  logic [1:0]                         wls,
    input  logic                               pen,
    input  logic                               sticky_parity,
    input  logic                               eps,
    input  logic                               stb,
    input  logic                               ovr_clr_i,
    input  logic                               rx_ready_i,
    output logic                               rx_valid_o,
    output logic [7:0]                         rx_data_o,
    output logic                               parity_error_o,
    output logic                               frame_error_o,
    output logic                               break_o,
    output logic                               overrun_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam logic [TW-1:0]    T_LO    = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0]    T_MID   = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0]    T_HI    = TW'(OVERSAMPLE/2 + 1);
    localparam logic [TW-1:0]    T_END   = TW'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HI
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    always_ff @(posedge sys_clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
    end
    assign rxd_s = sync_q[SYNC_STAGES-1];

    state_t         state;
    logic [TW-1:0]  tcnt;
    logic           s_lo, s_mid;
    logic [2:0]     bit_idx;
    logic [7:0]     data_q;
    logic           par_err_q, frm_err_q, par_zero_q, brk_q;
    logic [1:0]     wls_q;
    logic           pen_q, sp_q, eps_q, stb_q;
    logic           push_q;
    logic [10:0]    entry_q;

    logic       maj, resolve, wrap, exp_par, brk_now;
    logic [2:0] last_idx;

    assign maj      = (s_lo & s_mid) | (s_lo & rxd_s) | (s_mid & rxd_s);
    assign resolve  = baud_tick && (tcnt == T_HI);
    assign wrap     = baud_tick && (tcnt == T_END);
    assign last_idx = 3'd4 + {1'b0, wls_q};
    assign brk_now  = (data_q == 8'h00) && par_zero_q && !maj;

    // Unused data MSBs are held at zero, so a full-width reduction is exact.
    always_comb begin
        exp_par = 1'b0;
        case ({sp_q, eps_q})
            2'b00: exp_par = ~^data_q;
            2'b01: exp_par = ^data_q;
            2'b10: exp_par = 1'b1;
            2'b11: exp_par = 1'b0;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tcnt       <= '0;
            s_lo       <= 1'b1;
            s_mid      <= 1'b1;
            bit_idx    <= '0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            par_zero_q <= 1'b1;
            brk_q      <= 1'b0;
            wls_q      <= '0;
            pen_q      <= 1'b0;
            sp_q       <= 1'b0;
            eps_q      <= 1'b0;
            stb_q      <= 1'b0;
            push_q     <= 1'b0;
            entry_q    <= '0;
        end else begin
            push_q <= 1'b0;
            if (baud_tick && state != S_IDLE && state != S_WAIT_HI) begin
                tcnt <= (tcnt == T_END) ? '0 : tcnt + TW'(1);
                if (tcnt == T_LO)  s_lo  <= rxd_s;
                if (tcnt == T_MID) s_mid <= rxd_s;
            end
            case (state)
                S_IDLE: begin
                    if (baud_tick && !rxd_s) begin
                        state      <= S_START;
                        tcnt       <= '0;
                        wls_q      <= wls;
                        pen_q      <= pen;
                        sp_q       <= sticky_parity;
                        eps_q      <= eps;
                        stb_q      <= stb;
                        bit_idx    <= '0;
                        data_q     <= '0;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        par_zero_q <= 1'b1;
                        brk_q      <= 1'b0;
                    end
                end
                S_START: begin
                    if (resolve && maj) state <= S_IDLE;
                    else if (wrap)      state <= S_DATA;
                end
                S_DATA: begin
                    if (resolve) data_q[bit_idx] <= maj;
                    if (wrap) begin
                        if (bit_idx == last_idx) state <= pen_q ? S_PARITY : S_STOP1;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (resolve) begin
                        par_err_q  <= (maj != exp_par);
                        par_zero_q <= ~maj;
                    end
                    if (wrap) state <= S_STOP1;
                end
                S_STOP1: begin
                    if (resolve) begin
                        frm_err_q <= ~maj;
                        brk_q     <= brk_now;
                        if (!stb_q) begin
                            push_q  <= 1'b1;
                            entry_q <= {brk_now, ~maj, par_err_q, data_q};
                            state   <= maj ? S_IDLE : S_WAIT_HI;
                        end
                    end
                    if (wrap) state <= S_STOP2;
                end
                S_STOP2: begin
                    if (resolve) begin
                        push_q  <= 1'b1;
                        entry_q <= {brk_q, frm_err_q | ~maj, par_err_q, data_q};
                        state   <= maj ? S_IDLE : S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (rxd_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [10:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             ovr_q;
    logic             pop, full, wr_en;
    logic [10:0]      head;

    assign pop   = rx_valid_o && rx_ready_i;
    assign full  = (count_q == DEPTH_C);
    assign wr_en = push_q && (!full || pop);

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= entry_q;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!wr_en && pop) count_q <= count_q - CNT_W'(1);
            // A drop and a clear in the same cycle leave the flag set.
            if (push_q && full && !pop) ovr_q <= 1'b1;
            else if (ovr_clr_i)         ovr_q <= 1'b0;
        end
    end

    assign head           = mem[rd_ptr];
    assign rx_valid_o     = (count_q != '0);
    assign rx_data_o      = rx_valid_o ? head[7:0] : 8'h00;
    assign parity_error_o = rx_valid_o & head[8];
    assign frame_error_o  = rx_valid_o & head[9];
    assign break_o        = rx_valid_o & head[10];
    assign overrun_o      = ovr_q;
    assign fifo_count_o   = count_q;

endmodule
